// File: rtl/pe_pkg.sv
// Shared encodings, defaults and the signed clamp helper for the unified PE array.
package pe_pkg;
  typedef enum logic [1:0] {
    MODE_MAC = 2'b00,
    MODE_MUL = 2'b01,
    MODE_ADD = 2'b10,
    MODE_RSV = 2'b11
  } op_mode_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

  // Per-beat control travelling alongside stage-1 data.
  typedef struct packed {
    logic first;
    logic last;
  } beat_ctl_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC_BITS = 12;
  localparam int SAT_W         = 64;

  // Clamp a signed value into a signed range of the given bit width.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                      input int width);
    logic signed [SAT_W-1:0] hi, lo;
    hi = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction
endpackage

// File: rtl/unified_pe_array_if.sv
// Operand/result handshake bundle between the operand buffers, the PE array and requant.
interface unified_pe_array_if
  import pe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 8
);
    op_mode_e                       op_mode;
    logic [CNT_W-1:0]               acc_len;
    logic                           in_valid;
    logic                           in_ready;
    logic [LANES-1:0][DATA_W-1:0]   in_a;
    logic [LANES-1:0][DATA_W-1:0]   in_b;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES-1:0][DATA_W-1:0]   out_val;
    logic [LANES-1:0]               out_sat;

    modport master (
        output op_mode, acc_len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_val, out_sat
    );

    modport slave (
        input  op_mode, acc_len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_val, out_sat
    );
endinterface

// File: rtl/pe_lane.sv
// One PE lane: stage-1 product/sum, stage-2 wide saturating accumulator, output clamp.
// UNIFIED_PE_ROUND_EN selects round-half-up products instead of floor truncation.
module pe_lane
  import pe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     load,
    input  logic                     upd,
    input  logic                     first,
    input  op_mode_e                 mode,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic [DATA_W-1:0]        val,
    output logic                     sat
);
    localparam int PW = 2 * DATA_W;
`ifdef UNIFIED_PE_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC_BITS - 1);
`else
    localparam logic signed [PW-1:0] HALF = '0;
`endif

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] p_next, p, acc, acc_next;
    logic signed [SAT_W-1:0] sum_w, clamp_w;

    always_comb begin
        prod = PW'(a) * PW'(b) + HALF;
        case (mode)
            MODE_MAC, MODE_MUL: p_next = ACC_W'(prod >>> FRAC_BITS);
            MODE_ADD:           p_next = ACC_W'(a) + ACC_W'(b);
            default:            p_next = '0;
        endcase
    end

    // First beat reloads so back-to-back vectors never see the previous total.
    always_comb begin
        sum_w    = SAT_W'(acc) + SAT_W'(p);
        acc_next = first ? p : ACC_W'(saturate(sum_w, ACC_W));
        clamp_w  = saturate(SAT_W'(acc), DATA_W);
        val      = clamp_w[DATA_W-1:0];
        sat      = (clamp_w != SAT_W'(acc));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p   <= '0;
            acc <= '0;
        end else if (clear) begin
            p   <= '0;
            acc <= '0;
        end else if (en) begin
            if (load) p   <= p_next;
            if (upd)  acc <= acc_next;
        end
    end
endmodule

// File: rtl/unified_pe_array.sv
// Multi-lane pipelined PE: shared MAC-length FSM, valid pipeline and handshake over pe_lane copies.
module unified_pe_array
  import pe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int LANES     = 4,
    parameter int ACC_W     = 32,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    unified_pe_array_if.slave   bus,
    output logic                busy
);
    localparam int STAGES = 1;  // vld_pipe[0] = stage 1, vld_pipe[STAGES] = output register

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, len_q, len_nxt, eff_len;
    op_mode_e         mode_q, mode_nxt, beat_mode;
    beat_ctl_t        beat, s1_ctl;
    logic [STAGES:0]  vld_pipe;
    logic             stall, en, accept;

    assign stall        = vld_pipe[STAGES] && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = en;
    assign accept       = bus.in_valid && en;
    assign bus.out_valid = vld_pipe[STAGES];
    assign busy         = (state == ST_ACCUM) || (|vld_pipe);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        mode_nxt  = mode_q;
        beat      = '{first: 1'b1, last: 1'b1};
        beat_mode = bus.op_mode;
        eff_len   = (bus.acc_len == '0) ? CNT_W'(1) : bus.acc_len;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    mode_nxt = bus.op_mode;
                    len_nxt  = eff_len;
                    if (bus.op_mode == MODE_MAC && eff_len != CNT_W'(1)) begin
                        beat.last = 1'b0;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                // Mode and length stay as latched on the vector's first beat.
                beat_mode = mode_q;
                beat      = '{first: 1'b0, last: (cnt == len_q - CNT_W'(1))};
                if (accept) begin
                    if (beat.last) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= MODE_MAC;
        end else if (clear) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= MODE_MAC;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            len_q  <= len_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_ctl   <= '0;
        end else if (clear) begin
            vld_pipe <= '0;
            s1_ctl   <= '0;
        end else if (en) begin
            vld_pipe[0]      <= accept;
            vld_pipe[STAGES] <= vld_pipe[0] && s1_ctl.last;
            if (accept) s1_ctl <= beat;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane #(
            .DATA_W    (DATA_W),
            .FRAC_BITS (FRAC_BITS),
            .ACC_W     (ACC_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .en    (en),
            .load  (accept),
            .upd   (vld_pipe[0]),
            .first (s1_ctl.first),
            .mode  (beat_mode),
            .a     (bus.in_a[i]),
            .b     (bus.in_b[i]),
            .val   (bus.out_val[i]),
            .sat   (bus.out_sat[i])
        );
    end
endmodule

// File: tb/tb_unified_pe_array.sv
// Directed bench for unified_pe_array: single-beat vector table plus MAC, stall and abort sequences.
module tb_unified_pe_array;
    import pe_pkg::*;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int CW    = 8;

    typedef logic [LANES-1:0][DW-1:0] vec_t;

    typedef struct {
        op_mode_e         mode;
        logic [CW-1:0]    len;
        vec_t             a;
        vec_t             b;
        vec_t             exp_val;
        logic [LANES-1:0] exp_sat;
        string            name;
    } vec_rec_t;

`ifdef UNIFIED_PE_ROUND_EN
    localparam logic [DW-1:0] R_POS = 16'h0001;
    localparam logic [DW-1:0] R_NEG = 16'h0000;
`else
    localparam logic [DW-1:0] R_POS = 16'h0000;
    localparam logic [DW-1:0] R_NEG = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic reset, clear, busy;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    vec_t             q_val[$];
    logic [LANES-1:0] q_sat[$];
    int               q_cyc[$];

    unified_pe_array_if #(.LANES(LANES), .DATA_W(DW), .CNT_W(CW)) bus ();

    unified_pe_array #(
        .DATA_W(DW), .FRAC_BITS(12), .LANES(LANES), .ACC_W(32), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A result is transferred at the posedge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            q_val.push_back(bus.out_val);
            q_sat.push_back(bus.out_sat);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t rep(input logic [DW-1:0] x);
        return {LANES{x}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flush_q();
        q_val.delete();
        q_sat.delete();
        q_cyc.delete();
    endtask

    // Called just after a posedge; returns after the accepting edge, again just past it.
    task automatic send(input op_mode_e m, input logic [CW-1:0] len, input vec_t a,
                        input vec_t b, output int acc_cyc);
        bit done = 0;
        acc_cyc      = -1;
        bus.op_mode  = m;
        bus.acc_len  = len;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int n, input string name);
        for (int k = 0; k < 40 && q_val.size() < n; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, 64'(q_val.size()), 64'(n));
        @(posedge clk);
        #1;
    endtask

    vec_rec_t tv[8];
    int       t_acc, t_prev, t_last;
    int       bp_acc[6];

    initial begin
        tv[0] = '{MODE_MUL, 8'd1, rep(16'h2000), rep(16'h1800), rep(16'h3000), 4'b0000, "mul_uniform"};
        tv[1] = '{MODE_ADD, 8'd1, {16'hFFFF, 16'h0100, 16'h8000, 16'h7000},
                  {16'h0001, 16'h0200, 16'hF000, 16'h2000},
                  {16'h0000, 16'h0300, 16'h8000, 16'h7FFF}, 4'b0011, "add_clamp"};
        tv[2] = '{MODE_MUL, 8'd1, {16'h0001, 16'h7FFF, 16'hE000, 16'h2000},
                  {16'h0800, 16'h7FFF, 16'h1800, 16'h1800},
                  {R_POS, 16'h7FFF, 16'hD000, 16'h3000}, 4'b0100, "mul_mixed"};
        tv[3] = '{MODE_MUL, 8'd1, {16'h1000, 16'h8000, 16'h8000, 16'hFFFF},
                  {16'h1000, 16'h7FFF, 16'h8000, 16'h0800},
                  {16'h1000, 16'h8000, 16'h7FFF, R_NEG}, 4'b0110, "mul_neg"};
        tv[4] = '{MODE_RSV, 8'd1, rep(16'h7000), rep(16'h7000), rep(16'h0000), 4'b0000, "reserved"};
        tv[5] = '{MODE_MAC, 8'd1, rep(16'h3000), rep(16'h2000), rep(16'h6000), 4'b0000, "mac_len1"};
        tv[6] = '{MODE_MAC, 8'd0, rep(16'h1000), rep(16'hF000), rep(16'hF000), 4'b0000, "mac_len0"};
        tv[7] = '{MODE_ADD, 8'd1, rep(16'hFF00), rep(16'hFF00), rep(16'hFE00), 4'b0000, "add_neg"};

        reset         = 1'b1;
        clear         = 1'b0;
        bus.op_mode   = MODE_MAC;
        bus.acc_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_val", 64'(bus.out_val), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            flush_q();
            send(tv[i].mode, tv[i].len, tv[i].a, tv[i].b, t_acc);
            drain(1, {tv[i].name, "_count"});
            if (q_val.size() > 0) begin
                check({tv[i].name, "_val"}, 64'(q_val[0]), 64'(tv[i].exp_val));
                check({tv[i].name, "_sat"}, 64'(q_sat[0]), 64'(tv[i].exp_sat));
                check({tv[i].name, "_latency"}, 64'(q_cyc[0] - t_acc), 64'd2);
            end
        end

        // MAC len 4; mode/len changes on later beats must be ignored.
        flush_q();
        send(MODE_MAC, 8'd4, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MUL, 8'd1, rep(16'h1000), rep(16'h1000), t_acc);
        check("mac4_busy_mid", 64'(busy), 64'd1);
        send(MODE_ADD, 8'd0, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MUL, 8'd1, rep(16'h1000), rep(16'h1000), t_last);
        drain(1, "mac4_count");
        if (q_val.size() > 0) begin
            check("mac4_val", 64'(q_val[0]), 64'(rep(16'h4000)));
            check("mac4_sat", 64'(q_sat[0]), 64'd0);
            check("mac4_latency", 64'(q_cyc[0] - t_last), 64'd2);
        end

        // len 3 (+7,+7,-7) with a bubble, then len 4 of +7 straight after.
        flush_q();
        send(MODE_MAC, 8'd3, rep(16'h7000), rep(16'h1000), t_acc);
        repeat (2) @(posedge clk);
        #1;
        send(MODE_ADD, 8'd1, rep(16'h7000), rep(16'h1000), t_acc);
        send(MODE_MAC, 8'd3, rep(16'h9000), rep(16'h1000), t_prev);
        send(MODE_MAC, 8'd4, rep(16'h7000), rep(16'h1000), t_acc);
        check("b2b_no_bubble", 64'(t_acc - t_prev), 64'd1);
        for (int k = 0; k < 3; k++) send(MODE_MAC, 8'd4, rep(16'h7000), rep(16'h1000), t_acc);
        drain(2, "mac_pair_count");
        if (q_val.size() > 1) begin
            check("mac3_val", 64'(q_val[0]), 64'(rep(16'h7000)));
            check("mac3_sat", 64'(q_sat[0]), 64'd0);
            check("mac4sat_val", 64'(q_val[1]), 64'(rep(16'h7FFF)));
            check("mac4sat_sat", 64'(q_sat[1]), 64'hF);
        end

        // Backpressure: six MUL beats, out_ready low for a stretch mid-stream.
        flush_q();
        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(MODE_MUL, 8'd1, rep(DW'(k * 16'h1000)), rep(16'h1000), bp_acc[k-1]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_out_val", 64'(bus.out_val), 64'(rep(16'h2000)));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain(6, "bp_count");
        for (int k = 0; k < 6 && k < q_val.size(); k++)
            check($sformatf("bp_order_%0d", k), 64'(q_val[k]), 64'(rep(DW'((k + 1) * 16'h1000))));

        // Async reset part-way through a len-4 vector, then a clean len-2 vector.
        flush_q();
        send(MODE_MAC, 8'd4, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MAC, 8'd4, rep(16'h1000), rep(16'h1000), t_acc);
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_val", 64'(bus.out_val), 64'd0);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(MODE_MAC, 8'd2, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MAC, 8'd2, rep(16'h1000), rep(16'h1000), t_acc);
        drain(1, "post_rst_count");
        if (q_val.size() > 0) check("post_rst_val", 64'(q_val[0]), 64'(rep(16'h2000)));

        // Synchronous clear part-way through a len-4 vector.
        flush_q();
        send(MODE_MAC, 8'd4, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MAC, 8'd4, rep(16'h1000), rep(16'h1000), t_acc);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_val", 64'(bus.out_val), 64'd0);
        check("clr_sat", 64'(bus.out_sat), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        send(MODE_MAC, 8'd2, rep(16'h1000), rep(16'h1000), t_acc);
        send(MODE_MAC, 8'd2, rep(16'h1000), rep(16'h1000), t_acc);
        drain(1, "post_clr_count");
        if (q_val.size() > 0) check("post_clr_val", 64'(q_val[0]), 64'(rep(16'h2000)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
